// File: rtl/cache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared definitions for the parametrised cache data array.
//            Holds the default geometry, the address widths derived from it,
//            and the refill state encoding.
// Ports    : none (package)
// Options  : CACHE_DATA_PARITY_EN is consumed by cache_data_array_p only.
// Revision : 1.0  initial parametrised release
// ============================================================================
package cache_pkg;

  localparam int DEF_WORD_W        = 16;
  localparam int DEF_WORDS_PER_BLK = 8;
  localparam int DEF_NUM_SETS      = 64;
  localparam int DEF_NUM_WAYS      = 2;

  localparam int DEF_SET_W = $clog2(DEF_NUM_SETS);
  localparam int DEF_WAY_W = $clog2(DEF_NUM_WAYS);
  localparam int DEF_OFF_W = $clog2(DEF_WORDS_PER_BLK);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_fill_ctrl
// Purpose  : Line-refill sequencer and write-port arbiter.
//            Latches the refill target on fill_start, counts incoming refill
//            words, and merges refill words with CPU writes onto the single
//            array write port (refill word always wins).
// Ports    : fill_start/fill_set/fill_way  refill request and target
//            fill_valid/fill_data          refill word stream
//            wr_en/wr_set/wr_way/wr_word/wr_data  CPU store-hit write
//            fill_busy, fill_done, wr_ready       status to the controller
//            we/we_set/we_way/we_word/we_data     arbitrated array write
// Revision : 1.0  initial release
// ============================================================================
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int WORD_W        = DEF_WORD_W,
  parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
  parameter int NUM_SETS      = DEF_NUM_SETS,
  parameter int NUM_WAYS      = DEF_NUM_WAYS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fill_start,
  input  logic [$clog2(NUM_SETS)-1:0]      fill_set,
  input  logic [$clog2(NUM_WAYS)-1:0]      fill_way,
  input  logic                             fill_valid,
  input  logic [WORD_W-1:0]                fill_data,
  input  logic                             wr_en,
  input  logic [$clog2(NUM_SETS)-1:0]      wr_set,
  input  logic [$clog2(NUM_WAYS)-1:0]      wr_way,
  input  logic [$clog2(WORDS_PER_BLK)-1:0] wr_word,
  input  logic [WORD_W-1:0]                wr_data,
  output logic                             fill_busy,
  output logic                             fill_done,
  output logic                             wr_ready,
  output logic                             we,
  output logic [$clog2(NUM_SETS)-1:0]      we_set,
  output logic [$clog2(NUM_WAYS)-1:0]      we_way,
  output logic [$clog2(WORDS_PER_BLK)-1:0] we_word,
  output logic [WORD_W-1:0]                we_data
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int OFF_W = $clog2(WORDS_PER_BLK);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_BLK - 1);

  fill_state_t      state, state_nxt;
  logic [OFF_W-1:0] cnt;
  logic [SET_W-1:0] tgt_set;
  logic [WAY_W-1:0] tgt_way;
  logic             fill_word;
  logic             last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_word = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) state_nxt = FILL;
      end
      FILL: begin
        fill_word = fill_valid;
        if (fill_valid && (cnt == LAST_WORD)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last_word = fill_word && (cnt == LAST_WORD);

  // The counter wraps to zero on the last word, so no explicit clear is
  // needed on the way back to IDLE; the start clear covers any reuse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      tgt_set   <= '0;
      tgt_way   <= '0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= last_word;
      if ((state == IDLE) && fill_start) begin
        tgt_set <= fill_set;
        tgt_way <= fill_way;
        cnt     <= '0;
      end else if (fill_word) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign fill_busy = (state == FILL);
  assign wr_ready  = ~(fill_busy & fill_valid);

  // A CPU write that loses arbitration is simply dropped.
  assign we      = fill_word | (wr_en & wr_ready);
  assign we_set  = fill_word ? tgt_set   : wr_set;
  assign we_way  = fill_word ? tgt_way   : wr_way;
  assign we_word = fill_word ? cnt       : wr_word;
  assign we_data = fill_word ? fill_data : wr_data;

endmodule : cache_fill_ctrl
`default_nettype wire

// File: rtl/cache_data_array_p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_data_array_p
// Purpose  : Parametrised set-associative cache data array with a registered
//            read port, a CPU word-write port and a streaming line refill.
// Ports    : rd_en/rd_set/rd_way/rd_word -> rd_data/rd_valid (1-cycle latency)
//            wr_en/wr_set/wr_way/wr_word/wr_data, wr_ready (CPU store hit)
//            fill_start/fill_set/fill_way/fill_valid/fill_data,
//            fill_busy/fill_done (line refill)
//            rd_perr (only with CACHE_DATA_PARITY_EN defined)
// Options  : CACHE_DATA_PARITY_EN adds one even-parity bit per stored word
//            and the rd_perr output.
// Revision : 1.0  initial parametrised release
// ============================================================================
module cache_data_array_p
  import cache_pkg::*;
#(
  parameter int WORD_W        = DEF_WORD_W,
  parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
  parameter int NUM_SETS      = DEF_NUM_SETS,
  parameter int NUM_WAYS      = DEF_NUM_WAYS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rd_en,
  input  logic [$clog2(NUM_SETS)-1:0]      rd_set,
  input  logic [$clog2(NUM_WAYS)-1:0]      rd_way,
  input  logic [$clog2(WORDS_PER_BLK)-1:0] rd_word,
  output logic [WORD_W-1:0]                rd_data,
  output logic                             rd_valid,
`ifdef CACHE_DATA_PARITY_EN
  output logic                             rd_perr,
`endif
  input  logic                             wr_en,
  input  logic [$clog2(NUM_SETS)-1:0]      wr_set,
  input  logic [$clog2(NUM_WAYS)-1:0]      wr_way,
  input  logic [$clog2(WORDS_PER_BLK)-1:0] wr_word,
  input  logic [WORD_W-1:0]                wr_data,
  output logic                             wr_ready,
  input  logic                             fill_start,
  input  logic [$clog2(NUM_SETS)-1:0]      fill_set,
  input  logic [$clog2(NUM_WAYS)-1:0]      fill_way,
  input  logic                             fill_valid,
  input  logic [WORD_W-1:0]                fill_data,
  output logic                             fill_busy,
  output logic                             fill_done
);

  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int OFF_W  = $clog2(WORDS_PER_BLK);
  localparam int ADDR_W = SET_W + WAY_W + OFF_W;
  localparam int DEPTH  = NUM_SETS * NUM_WAYS * WORDS_PER_BLK;

  logic              we;
  logic [SET_W-1:0]  we_set;
  logic [WAY_W-1:0]  we_way;
  logic [OFF_W-1:0]  we_word;
  logic [WORD_W-1:0] we_data;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic              bypass;

  logic [WORD_W-1:0] mem [DEPTH];

  cache_fill_ctrl #(
    .WORD_W        (WORD_W),
    .WORDS_PER_BLK (WORDS_PER_BLK),
    .NUM_SETS      (NUM_SETS),
    .NUM_WAYS      (NUM_WAYS)
  ) u_fill_ctrl (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_set   (fill_set),
    .fill_way   (fill_way),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .wr_en      (wr_en),
    .wr_set     (wr_set),
    .wr_way     (wr_way),
    .wr_word    (wr_word),
    .wr_data    (wr_data),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .wr_ready   (wr_ready),
    .we         (we),
    .we_set     (we_set),
    .we_way     (we_way),
    .we_word    (we_word),
    .we_data    (we_data)
  );

  // Flat storage index: set is the most significant field.
  assign waddr  = {we_set, we_way, we_word};
  assign raddr  = {rd_set, rd_way, rd_word};
  // Write-first: a same-cycle accepted write to the read address forwards.
  assign bypass = we && (waddr == raddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= we_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= bypass ? we_data : mem[raddr];
    end
  end

`ifdef CACHE_DATA_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
    end else if (we) begin
      par_mem[waddr] <= ^we_data;
    end
  end

  // Forwarded data has freshly computed parity, so it can never flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_perr <= 1'b0;
    end else if (rd_en) begin
      rd_perr <= bypass ? 1'b0 : (par_mem[raddr] != (^mem[raddr]));
    end
  end
`endif

endmodule : cache_data_array_p
`default_nettype wire

// File: tb/tb_cache_data_array_p.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_data_array_p
// Purpose  : Self-checking bench for cache_data_array_p. A reference model
//            (plain array plus refill bookkeeping) predicts every read; a
//            monitor pops predictions whenever rd_valid is seen.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_data_array_p;

  localparam int WORD_W = 16;
  localparam int WPB    = 8;
  localparam int NSETS  = 64;
  localparam int NWAYS  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_set = '0;
  logic        rd_way = 1'b0;
  logic [2:0]  rd_word = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_set = '0;
  logic        wr_way = 1'b0;
  logic [2:0]  wr_word = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        fill_start = 1'b0;
  logic [5:0]  fill_set = '0;
  logic        fill_way = 1'b0;
  logic        fill_valid = 1'b0;
  logic [15:0] fill_data = '0;
  logic        fill_busy;
  logic        fill_done;
`ifdef CACHE_DATA_PARITY_EN
  logic        rd_perr;
`endif

  cache_data_array_p #(
    .WORD_W(WORD_W), .WORDS_PER_BLK(WPB), .NUM_SETS(NSETS), .NUM_WAYS(NWAYS)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_set(rd_set), .rd_way(rd_way), .rd_word(rd_word),
    .rd_data(rd_data), .rd_valid(rd_valid),
`ifdef CACHE_DATA_PARITY_EN
    .rd_perr(rd_perr),
`endif
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_word(wr_word),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_set(fill_set), .fill_way(fill_way),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] model [NSETS][NWAYS][WPB];
  bit          m_busy, m_done;
  int          m_set, m_way, m_cnt;
  logic [15:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++)
        for (int o = 0; o < WPB; o++) model[s][w][o] = '0;
    m_busy = 0; m_done = 0; m_set = 0; m_way = 0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; fill_start = 0; fill_valid = 0;
  endtask

  // Called at a falling edge after the inputs for the next rising edge have
  // been set. Checks status outputs, advances the model, then waits for the
  // following falling edge.
  task automatic cyc();
    bit fill_w, cpu_w;
    #1;
    chk("fill_busy", fill_busy, m_busy);
    chk("fill_done", fill_done, m_done);
    chk("wr_ready",  wr_ready,  !(m_busy && fill_valid));
    fill_w = m_busy && fill_valid;
    cpu_w  = wr_en && !fill_w;
    if (fill_w) model[m_set][m_way][m_cnt] = fill_data;
    else if (cpu_w) model[wr_set][wr_way][wr_word] = wr_data;
    if (rd_en) exp_q.push_back(model[rd_set][rd_way][rd_word]);
    m_done = 0;
    if (!m_busy) begin
      if (fill_start) begin
        m_busy = 1; m_set = fill_set; m_way = fill_way; m_cnt = 0;
      end
    end else if (fill_w) begin
      if (m_cnt == WPB - 1) begin
        m_busy = 0; m_done = 1;
      end
      m_cnt = (m_cnt + 1) % WPB;
    end
    @(negedge clk);
  endtask

  task automatic do_read(input int s, input int w, input int o);
    idle_inputs();
    rd_en = 1; rd_set = 6'(s); rd_way = w[0]; rd_word = 3'(o);
    cyc();
  endtask

  task automatic do_write(input int s, input int w, input int o, input logic [15:0] d);
    idle_inputs();
    wr_en = 1; wr_set = 6'(s); wr_way = w[0]; wr_word = 3'(o); wr_data = d;
    cyc();
  endtask

  task automatic fill_word_cyc(input logic [15:0] d);
    idle_inputs();
    fill_valid = 1; fill_data = d;
    cyc();
  endtask

  // Mid-cycle asynchronous reset with an idle cycle before it so no read is
  // left in flight.
  task automatic do_reset();
    idle_inputs();
    cyc();
    #2 rst = 1;
    #1;
    chk("rst_rd_data",   rd_data,   16'h0);
    chk("rst_rd_valid",  rd_valid,  1'b0);
    chk("rst_fill_busy", fill_busy, 1'b0);
    chk("rst_fill_done", fill_done, 1'b0);
    model_clear();
    @(negedge clk);
    rst = 0;
  endtask

  // Monitor: compare every presented read against the oldest prediction.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_valid: got unexpected read data %h, expected none", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
`ifdef CACHE_DATA_PARITY_EN
          chk("rd_perr", rd_perr, 1'b0);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #3;
    chk("init_rd_data",   rd_data,   16'h0);
    chk("init_rd_valid",  rd_valid,  1'b0);
    chk("init_fill_busy", fill_busy, 1'b0);
    chk("init_fill_done", fill_done, 1'b0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Read of untouched storage after reset
    do_read(5, 1, 3);

    // Write then read back; same-cycle read+write forwards new data
    do_write(10, 0, 2, 16'hBEEF);
    do_read(10, 0, 2);
    idle_inputs();
    wr_en = 1; wr_set = 6'd10; wr_way = 1'b0; wr_word = 3'd2; wr_data = 16'h1234;
    rd_en = 1; rd_set = 6'd10; rd_way = 1'b0; rd_word = 3'd2;
    cyc();

    // fill_valid while idle must not touch the array
    fill_word_cyc(16'hDEAD);
    fill_word_cyc(16'hDEAD);

    // Line refill of set 63 way 1 with a gap, a stray fill_start and a
    // colliding CPU write that must be dropped
    do_write(20, 1, 4, 16'h5555);
    idle_inputs();
    fill_start = 1; fill_set = 6'd63; fill_way = 1'b1;
    cyc();
    for (int i = 0; i < WPB; i++) begin
      idle_inputs();
      fill_valid = 1; fill_data = 16'h1000 + 16'(i);
      if (i == 1) begin
        wr_en = 1; wr_set = 6'd20; wr_way = 1'b1; wr_word = 3'd4; wr_data = 16'hAAAA;
      end
      cyc();
      if (i == 3) begin
        idle_inputs();
        fill_start = 1; fill_set = 6'd3; fill_way = 1'b0;
        cyc();
        idle_inputs();
        cyc();
      end
    end
    idle_inputs();
    cyc();
    for (int o = 0; o < WPB; o++) do_read(63, 1, o);
    do_read(20, 1, 4);
    do_write(20, 1, 4, 16'hAAAA);
    do_read(20, 1, 4);
    do_read(3, 0, 0);

    // Randomised traffic over a few hot sets to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      int sp [4];
      sp = '{0, 1, 10, 63};
      idle_inputs();
      rd_en      = ($urandom_range(0, 1) == 1);
      rd_set     = 6'(sp[$urandom_range(0, 3)]);
      rd_way     = 1'($urandom_range(0, 1));
      rd_word    = 3'($urandom_range(0, 7));
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_set     = 6'(sp[$urandom_range(0, 3)]);
      wr_way     = 1'($urandom_range(0, 1));
      wr_word    = 3'($urandom_range(0, 7));
      wr_data    = 16'($urandom);
      fill_start = ($urandom_range(0, 15) == 0);
      fill_set   = 6'(sp[$urandom_range(0, 3)]);
      fill_way   = 1'($urandom_range(0, 1));
      fill_valid = ($urandom_range(0, 1) == 1);
      fill_data  = 16'($urandom);
      cyc();
    end
    idle_inputs();
    cyc();
    for (int o = 0; o < WPB; o++) do_read(63, 1, o);

    // Reset part-way through a refill: everything reads back as zero
    idle_inputs();
    cyc();
    while (m_busy) fill_word_cyc(16'h7777);
    idle_inputs();
    fill_start = 1; fill_set = 6'd1; fill_way = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) fill_word_cyc(16'h2000 + 16'(i));
    do_reset();
    for (int o = 0; o < WPB; o++) do_read(1, 0, o);
    do_read(10, 0, 2);
    idle_inputs();
    cyc();
    cyc();

    chk("pending_reads", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cache_data_array_p
`default_nettype wire
